conv_out_quant: RTL and testbench

CONV_OUT_QUANT -- requirements
Module: conv_out_quant

---
 rtl/conv_out_quant_pkg.sv | 19 +
 rtl/conv_out_fifo.sv | 56 +++++
 rtl/conv_out_quant.sv | 140 ++++++++++++++
 tb/tb_conv_out_quant.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_out_quant_pkg.sv
// Shared encodings and default sizes for the convolution output quantiser.
// The optional per-frame clamp counter (SAT_COUNT_EN) uses SAT_CNT_W from here.
package conv_out_quant_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_IN_W         = 20;
    localparam int DEF_OUT_W        = 12;
    localparam int DEF_ADDR_W       = 17;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int DEF_FRAME_PIXELS = 2500;
    localparam int SAT_CNT_W        = 12;

endpackage

// File: rtl/conv_out_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers wrap modulo DEPTH (power of two)
// and a separate level counter tells full from empty. Head reads 0 when empty.
module conv_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             do_push;
    logic             do_pop;

    assign valid   = (level != '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign do_pop  = pop && valid;
    // a full FIFO still accepts a write when the head leaves on the same edge
    assign do_push = push && (!full || do_pop);
    assign rdata   = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (!do_push && do_pop) level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/conv_out_quant.sv
// Rounds, shifts and clamps conv2d results into unsigned pixels and buffers them for a sink.
// Define SAT_COUNT_EN to add the sat_cnt port counting clamped samples per frame.
//   state    | meaning
//   ST_IDLE  | after reset, results ignored until start
//   ST_RUN   | accepting results until FRAME_PIXELS have been seen
//   ST_DRAIN | frame complete, waiting for the FIFO to empty
//   ST_DONE  | frame delivered, done high until the next start
module conv_out_quant
    import conv_out_quant_pkg::*;
#(
    parameter int IN_W         = DEF_IN_W,
    parameter int OUT_W        = DEF_OUT_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int FRAME_PIXELS = DEF_FRAME_PIXELS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        shift,
    input  logic              in_we,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [OUT_W-1:0]  out_data,
    output logic              done,
    output logic              overflow
`ifdef SAT_COUNT_EN
    ,
    output logic [SAT_CNT_W-1:0] sat_cnt
`endif
);

    localparam int CNT_W = $clog2(FRAME_PIXELS + 1);
    localparam int ENT_W = ADDR_W + OUT_W;
    localparam logic signed [IN_W:0] PIX_MAX = (IN_W+1)'((1 << OUT_W) - 1);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   count;
    logic [3:0]         shift_q;
    logic               run;
    logic               accept;
    logic               last;
    logic               pop;
    logic               full;
    logic [ENT_W-1:0]   head;
    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] bias;
    logic signed [IN_W:0] rounded;
    logic signed [IN_W:0] shifted;
    logic [OUT_W-1:0]   pix;

    assign accept = run && in_we && !start;
    assign last   = accept && (count == CNT_W'(FRAME_PIXELS - 1));
    assign pop    = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = ST_RUN;
        end else begin
            case (state)
                ST_IDLE:  state_nx = ST_IDLE;
                ST_RUN:   if (last) state_nx = ST_DRAIN;
                ST_DRAIN: if (!out_valid) state_nx = ST_DONE;
                ST_DONE:  state_nx = ST_DONE;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        run  = (state == ST_RUN);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            shift_q  <= '0;
            overflow <= 1'b0;
        end else if (start) begin
            count    <= '0;
            shift_q  <= shift;
            overflow <= 1'b0;
        end else if (accept) begin
            count <= count + 1'b1;
            if (full && !pop) overflow <= 1'b1;
        end
    end

    // one extra bit of headroom keeps the rounding add from wrapping
    always_comb begin
        ext     = {in_data[IN_W-1], in_data};
        bias    = {{IN_W{1'b0}}, (shift_q != 4'd0)} << (shift_q - 4'd1);
        rounded = ext + bias;
        shifted = rounded >>> shift_q;
        if (shifted[IN_W])          pix = '0;
        else if (shifted > PIX_MAX) pix = '1;
        else                        pix = shifted[OUT_W-1:0];
    end

    conv_out_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (start),
        .push  (accept),
        .pop   (out_ready),
        .wdata ({in_addr, pix}),
        .rdata (head),
        .valid (out_valid),
        .full  (full)
    );

    assign out_addr = head[ENT_W-1:OUT_W];
    assign out_data = head[OUT_W-1:0];

`ifdef SAT_COUNT_EN
    logic clamp;
    assign clamp = shifted[IN_W] || (shifted > PIX_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     sat_cnt <= '0;
        else if (start)                              sat_cnt <= '0;
        else if (accept && clamp && sat_cnt != '1)   sat_cnt <= sat_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_conv_out_quant.sv
// Scoreboard bench for conv_out_quant: expected pixels are queued when driven and
// compared as the sink pops them; scenario tasks add inline checks of their own.
module tb_conv_out_quant;

    localparam int IN_W   = 20;
    localparam int OUT_W  = 12;
    localparam int ADDR_W = 17;
    localparam int DEPTH  = 4;
    localparam int FRAME  = 2500;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [3:0]        shift = '0;
    logic              in_we = 1'b0;
    logic [ADDR_W-1:0] in_addr = '0;
    logic [IN_W-1:0]   in_data = '0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [ADDR_W-1:0] out_addr;
    logic [OUT_W-1:0]  out_data;
    logic              done;
    logic              overflow;
`ifdef SAT_COUNT_EN
    logic [11:0]       sat_cnt;
`endif

    conv_out_quant #(
        .IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W),
        .FIFO_DEPTH(DEPTH), .FRAME_PIXELS(FRAME)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .shift(shift),
        .in_we(in_we), .in_addr(in_addr), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data),
        .done(done), .overflow(overflow)
`ifdef SAT_COUNT_EN
        , .sat_cnt(sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [OUT_W-1:0]  data;
    } ent_t;

    ent_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   pop_cnt = 0;
    int   m_occ = 0;
    int   m_cnt = 0;
    int   m_sat = 0;
    int   m_shift = 0;
    bit   m_run = 1'b0;
    bit   m_ovf = 1'b0;

    function automatic logic [OUT_W-1:0] qmodel(input int d, input int sh, output bit sat);
        longint v;
        v = d;
        if (sh > 0) v = v + (longint'(1) <<< (sh - 1));
        v = v >>> sh;
        sat = 1'b1;
        if (v < 0) return 12'd0;
        if (v > 4095) return 12'hFFF;
        sat = 1'b0;
        return v[OUT_W-1:0];
    endfunction

    // sink-side scoreboard: a pop happens on the next edge when valid and ready
    always @(negedge clk) begin : monitor
        ent_t e;
        if (!rst && out_valid && out_ready) begin
            pop_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected: got addr=%0d data=%0d, want no pop", out_addr, out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_addr !== e.addr || out_data !== e.data) begin
                    failures++;
                    $display("FAIL pop_entry: got addr=%0d data=%0d, want addr=%0d data=%0d",
                             out_addr, out_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic drive(input bit we, input int addr, input int data, input bit rdy);
        bit pop;
        bit sat;
        logic [OUT_W-1:0] q;
        in_we = we;
        in_addr = addr[ADDR_W-1:0];
        in_data = data[IN_W-1:0];
        out_ready = rdy;
        pop = (m_occ > 0) && rdy;
        if (we && m_run) begin
            q = qmodel(data, m_shift, sat);
            m_cnt++;
            if (sat && m_sat < 4095) m_sat++;
            if (m_occ < DEPTH || pop) begin
                exp_q.push_back({addr[ADDR_W-1:0], q});
                m_occ++;
            end else begin
                m_ovf = 1'b1;
            end
            if (m_cnt == FRAME) m_run = 1'b0;
        end
        if (pop) m_occ--;
        @(posedge clk);
        #1;
        in_we = 1'b0;
    endtask

    task automatic start_frame(input int sh);
        start = 1'b1;
        shift = sh[3:0];
        in_we = 1'b1;
        in_addr = '0;
        in_data = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        in_we = 1'b0;
        exp_q.delete();
        m_occ = 0; m_run = 1'b1; m_cnt = 0; m_ovf = 1'b0; m_sat = 0; m_shift = sh;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && m_occ > 0; i++) drive(1'b0, 0, 0, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, done, overflow} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got valid/done/ovf=%b, want 000", {out_valid, done, overflow});
        end
        checks++;
        if (out_addr !== '0 || out_data !== '0) begin
            failures++;
            $display("FAIL reset_head: got addr=%0d data=%0d, want 0 0", out_addr, out_data);
        end
`ifdef SAT_COUNT_EN
        checks++;
        if (sat_cnt !== 12'd0) begin
            failures++;
            $display("FAIL reset_sat_cnt: got %0d, want 0", sat_cnt);
        end
`endif
        rst = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, i + 1, 77, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_ignore: got valid=%b done=%b, want 0 0", out_valid, done);
        end
    endtask

    task automatic test_quant();
        start_frame(4);
        checks++;
        if ({out_valid, done, overflow} !== 3'b000) begin
            failures++;
            $display("FAIL start_flags: got valid/done/ovf=%b, want 000", {out_valid, done, overflow});
        end
        drive(1'b1, 5, 40, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 17'd5 || out_data !== 12'd3) begin
            failures++;
            $display("FAIL round_40_latency: got valid=%b addr=%0d data=%0d, want 1 5 3", out_valid, out_addr, out_data);
        end
        drive(1'b1, 6, 24, 1'b1);
        checks++;
        if (out_data !== 12'd2) begin
            failures++;
            $display("FAIL round_24: got %0d, want 2", out_data);
        end
        drive(1'b1, 7, -5, 1'b1);
        checks++;
        if (out_data !== 12'd0) begin
            failures++;
            $display("FAIL clamp_neg_shift4: got %0d, want 0", out_data);
        end
        drain();

        start_frame(0);
        drive(1'b1, 8, 100, 1'b0);
        checks++;
        if (out_data !== 12'd100) begin
            failures++;
            $display("FAIL shift0_100: got %0d, want 100", out_data);
        end
        drive(1'b1, 9, 5000, 1'b1);
        checks++;
        if (out_data !== 12'd4095) begin
            failures++;
            $display("FAIL clamp_high: got %0d, want 4095", out_data);
        end
        drive(1'b1, 10, -5, 1'b1);
        checks++;
        if (out_data !== 12'd0) begin
            failures++;
            $display("FAIL clamp_low: got %0d, want 0", out_data);
        end
        drain();
`ifdef SAT_COUNT_EN
        checks++;
        if (sat_cnt !== 12'd2) begin
            failures++;
            $display("FAIL sat_cnt_clamp: got %0d, want 2", sat_cnt);
        end
`endif
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL quant_drained: got left=%0d valid=%b ovf=%b, want 0 0 0", exp_q.size(), out_valid, overflow);
        end
    endtask

    task automatic test_random();
        start_frame(int'($urandom_range(1, 15)));
        for (int i = 0; i < 80; i++)
            drive(1'($urandom_range(0, 1)), i, int'($urandom) >>> 12, 1'($urandom_range(0, 2) == 0));
        drain();
        checks++;
        if (overflow !== m_ovf || exp_q.size() != 0) begin
            failures++;
            $display("FAIL random_overflow: got ovf=%b left=%0d, want ovf=%b left=0", overflow, exp_q.size(), m_ovf);
        end
`ifdef SAT_COUNT_EN
        checks++;
        if (sat_cnt !== 12'(m_sat)) begin
            failures++;
            $display("FAIL random_sat_cnt: got %0d, want %0d", sat_cnt, m_sat);
        end
`endif
    endtask

    task automatic test_backpressure();
        int p0;
        start_frame(0);
        for (int i = 0; i < 5; i++) drive(1'b1, 10 + i, 100 + i, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL bp_overflow: got valid=%b ovf=%b, want 1 1", out_valid, overflow);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 0, 0, 1'b0);
        checks++;
        if (out_addr !== 17'd10 || out_data !== 12'd100) begin
            failures++;
            $display("FAIL bp_hold: got addr=%0d data=%0d, want 10 100", out_addr, out_data);
        end
        p0 = pop_cnt;
        drain();
        checks++;
        if (pop_cnt - p0 != 4 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_held_entries: got pops=%0d valid=%b, want 4 0", pop_cnt - p0, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        start_frame(0);
        for (int i = 0; i < 4; i++) drive(1'b1, 20 + i, i, 1'b0);
        p0 = pop_cnt;
        drive(1'b1, 24, 4, 1'b1);
        checks++;
        if (overflow !== 1'b0 || out_addr !== 17'd21) begin
            failures++;
            $display("FAIL full_push_pop: got ovf=%b head=%0d, want 0 21", overflow, out_addr);
        end
        drain();
        checks++;
        if (pop_cnt - p0 != 5) begin
            failures++;
            $display("FAIL full_occupancy: got pops=%0d, want 5", pop_cnt - p0);
        end
    endtask

    task automatic test_full_frame();
        int p0;
        start_frame(1);
        p0 = pop_cnt;
        for (int i = 0; i < FRAME; i++) drive(1'b1, i, 2 * i, 1'b1);
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL frame_drain: got done=%b valid=%b, want 0 1", done, out_valid);
        end
        drive(1'b1, 9999, 7, 1'b1);
        for (int i = 0; i < 10 && done !== 1'b1; i++) drive(1'b0, 0, 0, 1'b1);
        checks++;
        if (done !== 1'b1 || overflow !== 1'b0 || pop_cnt - p0 != FRAME || exp_q.size() != 0) begin
            failures++;
            $display("FAIL frame_done: got done=%b ovf=%b pops=%0d, want 1 0 %0d", done, overflow, pop_cnt - p0, FRAME);
        end
        for (int i = 0; i < 2; i++) drive(1'b1, 1, 1, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL done_ignore: got valid=%b done=%b, want 0 1", out_valid, done);
        end
    endtask

    task automatic test_reset_mid_frame();
        int p0;
        start_frame(0);
        for (int i = 0; i < 997; i++) drive(1'b1, i, i & 1023, 1'b1);
        drive(1'b0, 0, 0, 1'b1);
        for (int i = 997; i < 1000; i++) drive(1'b1, i, 5, 1'b0);
        p0 = pop_cnt;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b0 || out_addr !== '0) begin
            failures++;
            $display("FAIL midreset_async: got valid=%b done=%b addr=%0d, want 0 0 0", out_valid, done, out_addr);
        end
        exp_q.delete();
        m_occ = 0;
        m_run = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) drive(1'b0, 0, 0, 1'b1);
        checks++;
        if (pop_cnt != p0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_no_pop: got pops=%0d valid=%b, want 0 0", pop_cnt - p0, out_valid);
        end
        start_frame(0);
        p0 = pop_cnt;
        for (int i = 0; i < FRAME; i++) drive(1'b1, i, i, 1'b1);
        for (int i = 0; i < 10 && done !== 1'b1; i++) drive(1'b0, 0, 0, 1'b1);
        checks++;
        if (done !== 1'b1 || pop_cnt - p0 != FRAME) begin
            failures++;
            $display("FAIL restart_count: got done=%b pops=%0d, want 1 %0d", done, pop_cnt - p0, FRAME);
        end
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_quant();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_full_frame();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
